// File: rtl/fir_pkg.sv
// Shared definitions for the time-multiplexed FIR: width helpers and FSM encoding.
package fir_pkg;

  // Ceiling log2, used for tap-index widths and accumulator growth.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(n)) r = 32'(i + 1);
    end
    return r;
  endfunction

  // Full-precision accumulator width: product width plus growth over all taps.
  function automatic int unsigned acc_width(input int unsigned dw,
                                            input int unsigned cw,
                                            input int unsigned nt);
    return dw + cw + clog2(nt);
  endfunction

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    OUT  = 2'd2
  } state_t;

endpackage

// File: rtl/fir_round_sat.sv
// Combinational round-half-up, arithmetic shift and saturation of a wide accumulator.
module fir_round_sat #(
  parameter int unsigned ACC_WIDTH  = 18,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned OUT_SHIFT  = 0
) (
  input  logic signed [ACC_WIDTH-1:0]  acc,
  output logic signed [DATA_WIDTH-1:0] res_c,
  output logic                         sat_c
);

  // One guard bit so the rounding increment can never wrap.
  localparam int unsigned EXT = ACC_WIDTH + 1;
  localparam logic signed [EXT-1:0] MAX_V =
    {{(EXT - DATA_WIDTH + 1){1'b0}}, {(DATA_WIDTH - 1){1'b1}}};
  localparam logic signed [EXT-1:0] MIN_V =
    {{(EXT - DATA_WIDTH + 1){1'b1}}, {(DATA_WIDTH - 1){1'b0}}};

  logic signed [EXT-1:0] ext;
  logic signed [EXT-1:0] rnd;

  assign ext = {acc[ACC_WIDTH-1], acc};

  // Add half an LSB of the output grid before shifting.
  if (OUT_SHIFT > 0) begin : g_round
    localparam logic signed [EXT-1:0] HALF = EXT'(1) << (OUT_SHIFT - 1);
    logic signed [EXT-1:0] sum;
    assign sum = ext + HALF;
    assign rnd = sum >>> OUT_SHIFT;
  end else begin : g_pass
    assign rnd = ext;
  end

  // Clamp to the signed output range and flag clipping.
  always_comb begin
    res_c = rnd[DATA_WIDTH-1:0];
    sat_c = 1'b0;
    if (rnd > MAX_V) begin
      res_c = MAX_V[DATA_WIDTH-1:0];
      sat_c = 1'b1;
    end else if (rnd < MIN_V) begin
      res_c = MIN_V[DATA_WIDTH-1:0];
      sat_c = 1'b1;
    end
  end

endmodule

// File: rtl/fir_mac.sv
// Single-multiplier FIR: one sample in, NUM_TAPS MAC cycles, one rounded output.
module fir_mac
  import fir_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned COEFF_WIDTH = 8,
  parameter int unsigned NUM_TAPS    = 4,
  parameter int unsigned OUT_SHIFT   = 0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic signed [DATA_WIDTH-1:0]  in_data,
  input  logic                          coeff_we,
  input  logic [clog2(NUM_TAPS)-1:0]    coeff_addr,
  input  logic signed [COEFF_WIDTH-1:0] coeff_data,
  output logic                          out_valid,
  output logic signed [DATA_WIDTH-1:0]  out_data,
  output logic                          out_sat
);

  localparam int unsigned AW        = clog2(NUM_TAPS);
  localparam int unsigned PW        = DATA_WIDTH + COEFF_WIDTH;
  localparam int unsigned ACC_WIDTH = acc_width(DATA_WIDTH, COEFF_WIDTH, NUM_TAPS);
  localparam logic [AW-1:0] LAST    = AW'(NUM_TAPS - 1);

  state_t state_q, state_d;

  logic signed [DATA_WIDTH-1:0]  smp_q   [NUM_TAPS];
  logic signed [COEFF_WIDTH-1:0] coeff_q [NUM_TAPS];

  logic [AW-1:0]               wr_q, wr_d;
  logic [AW-1:0]               rd_q, rd_d;
  logic [AW-1:0]               k_q, k_d;
  logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
  logic                        smp_we;

  logic                        in_ready_q, in_ready_d;
  logic                        out_valid_q, out_valid_d;
  logic signed [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                        out_sat_q, out_sat_d;

  logic signed [PW-1:0]         prod;
  logic signed [DATA_WIDTH-1:0] res_c;
  logic                         sat_c;

  // Single shared multiplier: sample walks back from newest, tap index walks up.
  assign prod = smp_q[rd_q] * coeff_q[k_q];

  fir_round_sat #(
    .ACC_WIDTH (ACC_WIDTH),
    .DATA_WIDTH(DATA_WIDTH),
    .OUT_SHIFT (OUT_SHIFT)
  ) u_round_sat (
    .acc  (acc_q),
    .res_c(res_c),
    .sat_c(sat_c)
  );

  // State, datapath and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      wr_q        <= '0;
      rd_q        <= '0;
      k_q         <= '0;
      acc_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
      for (int i = 0; i < NUM_TAPS; i++) begin
        smp_q[i]   <= '0;
        coeff_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      wr_q        <= wr_d;
      rd_q        <= rd_d;
      k_q         <= k_d;
      acc_q       <= acc_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sat_q   <= out_sat_d;
      if (smp_we) smp_q[wr_q] <= in_data;
      if (coeff_we) coeff_q[coeff_addr] <= coeff_data;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state_q;
    wr_d        = wr_q;
    rd_d        = rd_q;
    k_d         = k_q;
    acc_d       = acc_q;
    smp_we      = 1'b0;
    in_ready_d  = in_ready_q;
    out_valid_d = 1'b0;
    out_data_d  = out_data_q;
    out_sat_d   = out_sat_q;

    unique case (state_q)
      IDLE: begin
        in_ready_d = 1'b1;
        if (in_valid && in_ready_q) begin
          smp_we     = 1'b1;
          wr_d       = (wr_q == LAST) ? '0 : wr_q + AW'(1);
          rd_d       = wr_q;
          acc_d      = '0;
          k_d        = '0;
          in_ready_d = 1'b0;
          state_d    = MAC;
        end
      end
      MAC: begin
        in_ready_d = 1'b0;
        acc_d      = acc_q + ACC_WIDTH'(prod);
        rd_d       = (rd_q == '0) ? LAST : rd_q - AW'(1);
        if (k_q == LAST) begin
          k_d     = '0;
          state_d = OUT;
        end else begin
          k_d = k_q + AW'(1);
        end
      end
      OUT: begin
        in_ready_d  = 1'b1;
        out_valid_d = 1'b1;
        out_data_d  = res_c;
        out_sat_d   = sat_c;
        state_d     = IDLE;
      end
      default: begin
        state_d    = IDLE;
        in_ready_d = 1'b0;
      end
    endcase
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;

endmodule

// File: tb/tb_fir_mac.sv
// Directed bench for fir_mac: two instances (shift 0 and shift 1) share all inputs.
module tb_fir_mac;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic signed [7:0] in_data;
  logic              coeff_we;
  logic [1:0]        coeff_addr;
  logic signed [7:0] coeff_data;

  logic              in_ready0, out_valid0, out_sat0;
  logic signed [7:0] out_data0;
  logic              in_ready1, out_valid1, out_sat1;
  logic signed [7:0] out_data1;

  int n_cmp = 0;
  int n_err = 0;

  logic signed [7:0] r0, r1;
  logic              s0, s1;

  always #5 clk = ~clk;

  fir_mac #(.DATA_WIDTH(8), .COEFF_WIDTH(8), .NUM_TAPS(4), .OUT_SHIFT(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
    .in_data(in_data), .coeff_we(coeff_we), .coeff_addr(coeff_addr),
    .coeff_data(coeff_data), .out_valid(out_valid0), .out_data(out_data0),
    .out_sat(out_sat0)
  );

  fir_mac #(.DATA_WIDTH(8), .COEFF_WIDTH(8), .NUM_TAPS(4), .OUT_SHIFT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
    .in_data(in_data), .coeff_we(coeff_we), .coeff_addr(coeff_addr),
    .coeff_data(coeff_data), .out_valid(out_valid1), .out_data(out_data1),
    .out_sat(out_sat1)
  );

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_coeff(input logic [1:0] a, input logic signed [7:0] d);
    coeff_we   = 1'b1;
    coeff_addr = a;
    coeff_data = d;
    tick();
    coeff_we   = 1'b0;
  endtask

  task automatic set_all(input logic signed [7:0] d);
    for (int i = 0; i < 4; i++) wr_coeff(2'(i), d);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    check("rst_in_ready", in_ready0, 0);
    check("rst_out_valid", out_valid0, 0);
    check("rst_out_data", out_data0, 0);
    check("rst_out_sat", out_sat0, 0);
    rst_n = 1'b1;
    tick();
    check("rst_release_ready", in_ready0, 1);
  endtask

  // Present one sample, wait for its result; records both instances' outputs.
  task automatic send(input logic signed [7:0] x);
    int n;
    n = 0;
    while (!in_ready0 && n < 20) begin tick(); n++; end
    check("ready_wait_ok", (n < 20) ? 1 : 0, 1);
    in_valid = 1'b1;
    in_data  = x;
    tick();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid0 && n < 20) begin tick(); n++; end
    check("latency", n, 5);
    r0 = out_data0; s0 = out_sat0;
    r1 = out_data1; s1 = out_sat1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic signed [7:0] vin  [5];
    logic signed [7:0] vexp [5];
    logic signed [7:0] hs_in[4];
    int acc_cyc[$];
    int out_cyc[$];
    logic signed [7:0] out_v[$];
    int idx;
    logic took;
    int ov_seen;

    rst_n = 1'b0; in_valid = 1'b0; in_data = '0;
    coeff_we = 1'b0; coeff_addr = '0; coeff_data = '0;
    do_reset();

    // Moving sum
    set_all(8'sd1);
    vin  = '{8'sd1, 8'sd2, 8'sd3, 8'sd4, 8'sd5};
    vexp = '{8'sd1, 8'sd3, 8'sd6, 8'sd10, 8'sd14};
    for (int i = 0; i < 5; i++) begin
      send(vin[i]);
      check("msum_data", r0, vexp[i]);
      check("msum_sat", s0, 0);
    end

    // Impulse response from cleared history
    do_reset();
    for (int i = 0; i < 4; i++) wr_coeff(2'(i), 8'(i + 1));
    vin  = '{8'sd10, 8'sd0, 8'sd0, 8'sd0, 8'sd0};
    vexp = '{8'sd10, 8'sd20, 8'sd30, 8'sd40, 8'sd0};
    for (int i = 0; i < 5; i++) begin
      send(vin[i]);
      check("impulse_data", r0, vexp[i]);
    end

    // Positive and negative saturation
    set_all(8'sd127);
    for (int i = 0; i < 4; i++) send(8'sd127);
    check("satp_data", r0, 127);
    check("satp_flag", s0, 1);
    set_all(-8'sd128);
    for (int i = 0; i < 4; i++) begin
      send(8'sd127);
      check("satn_data", r0, -128);
      check("satn_flag", s0, 1);
    end

    // Rounding on the shift-1 instance; shift-0 passes through
    do_reset();
    wr_coeff(2'd0, 8'sd1);
    send(8'sd3);
    check("rnd_p3", r1, 2);
    check("rnd_p3_sat", s1, 0);
    check("pass_p3", r0, 3);
    send(-8'sd3);
    check("rnd_m3", r1, -1);
    check("pass_m3", r0, -3);
    send(8'sd2);
    check("rnd_p2", r1, 1);

    // Continuous in_valid: acceptance spacing, latency, ordering
    hs_in = '{8'sd11, 8'sd22, 8'sd33, 8'sd44};
    idx = 0;
    in_valid = 1'b1;
    in_data  = hs_in[0];
    for (int c = 0; c < 40; c++) begin
      took = in_valid && in_ready0;
      tick();
      if (took) begin
        acc_cyc.push_back(c);
        idx++;
        if (idx < 4) in_data = hs_in[idx];
        else in_valid = 1'b0;
      end
      if (out_valid0) begin
        out_cyc.push_back(c);
        out_v.push_back(out_data0);
      end
    end
    in_valid = 1'b0;
    check("hs_accept_count", acc_cyc.size(), 4);
    check("hs_out_count", out_cyc.size(), 4);
    if (acc_cyc.size() == 4 && out_cyc.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        check("hs_latency", out_cyc[i] - acc_cyc[i], 5);
        check("hs_data", out_v[i], hs_in[i]);
        if (i > 0) check("hs_spacing", acc_cyc[i] - acc_cyc[i-1], 6);
      end
    end

    // Reset in the middle of MAC
    set_all(8'sd1);
    send(8'sd5);
    check("pre_rst_sum", r0, 104);
    in_valid = 1'b1;
    in_data  = 8'sd7;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    ov_seen = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (out_valid0) ov_seen++;
    end
    check("midrst_in_ready", in_ready0, 0);
    check("midrst_out_data", out_data0, 0);
    rst_n = 1'b1;
    tick();
    if (out_valid0) ov_seen++;
    check("midrst_ready_after", in_ready0, 1);
    for (int i = 0; i < 6; i++) begin
      tick();
      if (out_valid0) ov_seen++;
    end
    check("midrst_no_out_valid", ov_seen, 0);
    send(8'sd9);
    check("post_rst_data", r0, 0);
    check("post_rst_sat", s0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fir_mac.md
# fir_mac

Time-multiplexed, single-multiplier FIR filter: the parametrised successor of the fully parallel FIR in the MSO signal-processing chain. It accepts samples through a valid/ready handshake and holds history in a circular sample buffer. Coefficients are runtime-writable. Each output is accumulated at full precision over NUM_TAPS cycles, then rounded, shifted and saturated back to DATA_WIDTH. It sits between the acquisition front end and the trigger/decimation stages, where sample rate is at most clk/(NUM_TAPS+2).

## Interface

- DATA_WIDTH, 8: signed sample width, input and output.
- COEFF_WIDTH, 8: signed coefficient width.
- NUM_TAPS, 4: number of taps; must be ≥ 2.
- OUT_SHIFT, 0: right shift applied to the accumulator before saturation; range 0..ACC_WIDTH-DATA_WIDTH.
- ACC_WIDTH (localparam): DATA_WIDTH+COEFF_WIDTH+clog2(NUM_TAPS).
- clk, in, 1: clock.
- rst_n, in, 1: reset; synchronous, active-low.
- in_valid, in, 1: in_data is valid.
- in_ready, out, 1: block can accept a sample.
- in_data, in, DATA_WIDTH: signed input sample.
- coeff_we, in, 1: coefficient write strobe.
- coeff_addr, in, clog2(NUM_TAPS): tap index; 0 weights the newest sample.
- coeff_data, in, COEFF_WIDTH: signed coefficient.
- out_valid, out, 1: one-cycle pulse marking a new output.
- out_data, out, DATA_WIDTH: signed filtered sample.
- out_sat, out, 1: set with out_valid when the result was clipped.

## Operation

- Reset values:
  - in_ready=0 during reset, 1 in the first cycle after reset.
  - out_valid=0, out_data=0, out_sat=0.
  - Sample buffer cleared to 0; coefficients cleared to 0; write pointer 0; state IDLE.
- FSM states:
  - IDLE: in_ready=1. On in_valid, write in_data at the write pointer, advance the pointer (wraps at NUM_TAPS-1→0), clear the accumulator and tap counter k, go to MAC.
  - MAC: in_ready=0. Each cycle, acc += x[newest-k mod NUM_TAPS] * h[k] and k increments. After k=NUM_TAPS-1, go to OUT.
  - OUT: in_ready=0. Register the rounded and saturated result, assert out_valid for 1 cycle, return to IDLE.
- Arithmetic:
  - Products are full width and sign-extended to ACC_WIDTH; accumulation never overflows.
  - If OUT_SHIFT>0: r = (acc + 2^(OUT_SHIFT-1)) >>> OUT_SHIFT, i.e. round half toward +inf.
  - If r exceeds the signed DATA_WIDTH range, clamp to max/min and set out_sat=1; otherwise out_sat=0.
  - out_data and out_sat hold their values until the next OUT state.
- No output backpressure. Downstream must capture on the out_valid pulse.
- Coefficient writes:
  - Accepted in any state and take effect from the next cycle.
  - A write during MAC may affect the in-flight output; software writes only while the filter is idle.
  - Writes and accepted samples in the same cycle are independent.
- in_valid while in_ready=0 is not consumed. The source must hold the sample, per standard valid/ready rules.
- Reset mid-operation, including in MAC: abort the computation, no out_valid, and apply full reset values.

## Timing

- Sample accepted at clock edge E0 (in_valid & in_ready).
- MAC occupies edges E1..E_NUM_TAPS.
- out_valid and out_data are high/valid in the cycle after edge E_(NUM_TAPS+1).
- in_ready returns to 1 in the same cycle out_valid is high, so back-to-back throughput is one sample per NUM_TAPS+2 clocks.
- in_ready is registered, with no combinational path from in_valid.

## Structure

- Shared package fir_pkg: clog2 function, ACC_WIDTH derivation, FSM state encoding (IDLE, MAC, OUT).
- One sub-module, fir_round_sat: combinational round, shift and saturate, with parameters ACC_WIDTH, DATA_WIDTH and OUT_SHIFT. It is reusable by later decimator blocks.
- Sample buffer and coefficient store are register arrays; the multiplier is a single inferred DSP.

## Test plan

- Moving sum:
  - Setup: NUM_TAPS=4, OUT_SHIFT=0, all h=1.
  - Stimulus: inputs 1,2,3,4,5.
  - Required: outputs 1,3,6,10,14; out_sat=0 throughout.
- Impulse response:
  - Setup: h=1,2,3,4.
  - Stimulus: input 10, then zeros.
  - Required: outputs 10,20,30,40,0.
- Saturation:
  - Setup: all h=127, OUT_SHIFT=0.
  - Stimulus: four inputs of 127.
  - Required: out_data=127 with out_sat=1. Then with all h=-128 and inputs 127, out_data=-128 with out_sat=1.
- Rounding:
  - Setup: OUT_SHIFT=1, h0=1, others 0.
  - Required: input 3 gives 2; input -3 gives -1; input 2 gives 1.
- Handshake and latency:
  - Stimulus: in_valid held high continuously.
  - Required: exactly one acceptance per 6 clocks (NUM_TAPS=4); out_valid exactly 5 clocks after each acceptance edge; no sample dropped or duplicated.
- Reset mid-MAC:
  - Stimulus: assert rst_n=0 at MAC k=2.
  - Required: no out_valid; in_ready=1 the cycle after release; next output computed from zeroed history and coefficients, i.e. 0.
